// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Write-back arbiter and sequencer for the 8x16-bit register file write port.
// Two requesters share the port: A (memory-load write-back) and B (ALU write-back).
// One request is accepted per cycle. The register file writes one nibble per cycle,
// so a full-word request becomes four consecutive quarter writes, quarters 0..3.
//
// Optional feature macro:
//   WB_RR_EN  defined   -> round-robin arbitration between A and B
//             undefined -> fixed priority, A always wins contention
//
// Ports:
//   clk                  system clock, rising edge
//   reset                synchronous, active-high reset
//   a_valid / a_ready    requester A handshake (accept = a_valid & a_ready)
//   a_reg                A destination register (indices 8..15 are invalid)
//   a_data               A write data; a nibble request writes a_data[3:0]
//   a_word               1 = full word (4 beats), 0 = single nibble
//   a_quarter            A target quarter for a nibble request
//   b_*                  same as a_* for requester B
//   wr_en                register-file write strobe
//   wr_reg               register-file write index
//   wr_data              register-file write data, active nibble in [3:0], rest zero
//   wr_quarter           register-file quarter select
//   busy                 a word sequence is in progress
//   err                  one-cycle pulse, aligned with the first beat of an accepted
//                        request whose register index is invalid
//
// Ready depends combinationally on the other requester's valid and on reset, but
// never on the requester's own valid.

module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_word,
  input  logic [1:0]        a_quarter,

  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_W-1:0]  b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_word,
  input  logic [1:0]        b_quarter,

  output logic              wr_en,
  output logic [REG_W-1:0]  wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        wr_quarter,
  output logic              busy,
  output logic              err
);

  typedef enum logic [0:0] {
    StIdle,
    StWord
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              bad_q, bad_d;

  logic              wr_en_q, wr_en_d;
  logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        wr_quarter_q, wr_quarter_d;
  logic              err_q, err_d;

  logic              prio_a;
  logic              a_fire, b_fire;

  // Selected request (A when A fires, otherwise B)
  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              sel_word;
  logic [1:0]        sel_quarter;
  logic              sel_bad;

  logic [3:0]        beat_nib;

`ifdef WB_RR_EN
  // Last-grant pointer: 1 = last accepted request came from B.
  logic last_b_q, last_b_d;
  assign prio_a = last_b_q;
`else
  assign prio_a = 1'b1;
`endif

  // Readiness: only in IDLE and never while reset is asserted.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset && (state_q == StIdle)) begin
      a_ready = ~b_valid | prio_a;
      b_ready = ~a_valid | ~prio_a;
    end
  end

  // At most one of these can be set: when both are valid exactly one is ready.
  assign a_fire = a_valid & a_ready;
  assign b_fire = b_valid & b_ready;

  always_comb begin
    sel_reg     = b_reg;
    sel_data    = b_data;
    sel_word    = b_word;
    sel_quarter = b_quarter;
    if (a_fire) begin
      sel_reg     = a_reg;
      sel_data    = a_data;
      sel_word    = a_word;
      sel_quarter = a_quarter;
    end
  end

  // Only indices 0..7 are writable.
  assign sel_bad = sel_reg[3];

  // Nibble of the latched word for the beat about to be driven.
  always_comb begin
    case (cnt_q)
      2'd0:    beat_nib = word_q[3:0];
      2'd1:    beat_nib = word_q[7:4];
      2'd2:    beat_nib = word_q[11:8];
      default: beat_nib = word_q[15:12];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    bad_d        = bad_q;
    wr_en_d      = 1'b0;
    err_d        = 1'b0;
    wr_reg_d     = wr_reg_q;
    wr_data_d    = wr_data_q;
    wr_quarter_d = wr_quarter_q;
`ifdef WB_RR_EN
    last_b_d     = last_b_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (a_fire || b_fire) begin
`ifdef WB_RR_EN
          last_b_d = b_fire;
`endif
          // Invalid index: consume the request but suppress every write strobe.
          wr_en_d  = ~sel_bad;
          err_d    = sel_bad;
          wr_reg_d = sel_reg;
          if (sel_word) begin
            // Beat 0 goes out now; beats 1..3 come from the latched word.
            word_d       = sel_data;
            bad_d        = sel_bad;
            cnt_d        = 2'd1;
            state_d      = StWord;
            wr_quarter_d = 2'd0;
            wr_data_d    = {{(DATA_W-4){1'b0}}, sel_data[3:0]};
          end else begin
            wr_quarter_d = sel_quarter;
            wr_data_d    = {{(DATA_W-4){1'b0}}, sel_data[3:0]};
          end
        end
      end

      StWord: begin
        wr_en_d      = ~bad_q;
        wr_quarter_d = cnt_q;
        wr_data_d    = {{(DATA_W-4){1'b0}}, beat_nib};
        cnt_d        = cnt_q + 2'd1;
        // Leaving on the last beat lets ready return while beat 3 is on the port.
        if (cnt_q == 2'd3) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      word_q       <= '0;
      bad_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
      wr_quarter_q <= 2'd0;
      err_q        <= 1'b0;
`ifdef WB_RR_EN
      last_b_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      bad_q        <= bad_d;
      wr_en_q      <= wr_en_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
      wr_quarter_q <= wr_quarter_d;
      err_q        <= err_d;
`ifdef WB_RR_EN
      last_b_q     <= last_b_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_reg     = wr_reg_q;
  assign wr_data    = wr_data_q;
  assign wr_quarter = wr_quarter_q;
  assign err        = err_q;
  assign busy       = (state_q == StWord);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. The reference model keeps a queue
// of future write-port cycles: every accepted request appends its beats, and the
// port is ready only when nothing is queued. Define WB_RR_EN for both files to
// check the round-robin build.

module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, a_word;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic [1:0]  a_quarter;
  logic        b_valid, b_ready, b_word;
  logic [3:0]  b_reg;
  logic [15:0] b_data;
  logic [1:0]  b_quarter;
  logic        wr_en, busy, err;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic [1:0]  wr_quarter;

  regfile_wb_arbiter #(
    .DATA_W(16),
    .REG_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .a_word    (a_word),
    .a_quarter (a_quarter),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .b_word    (b_word),
    .b_quarter (b_quarter),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .wr_quarter(wr_quarter),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        err;
    logic        busy;
    logic [3:0]  rg;
    logic [1:0]  q;
    logic [15:0] d;
  } beat_t;

  beat_t pend[$];
  beat_t cur;
  logic  last_b;
  logic  fired_a, fired_b;
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic logic prio();
`ifdef WB_RR_EN
    return last_b;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic exp_a_rdy();
    return !reset && (pend.size() == 0) && (!b_valid || prio());
  endfunction

  function automatic logic exp_b_rdy();
    return !reset && (pend.size() == 0) && (!a_valid || !prio());
  endfunction

  function automatic beat_t seen();
    return {wr_en, err, busy, wr_reg, wr_quarter, wr_data};
  endfunction

  task automatic accept(input logic [3:0] rg, input logic [15:0] d, input logic word,
                        input logic [1:0] q);
    beat_t b;
    logic  bad;
    bad = (rg >= 4'd8);
    if (word) begin
      for (int k = 0; k < 4; k++) begin
        b.en   = !bad;
        b.err  = bad && (k == 0);
        b.busy = (k < 3);
        b.rg   = rg;
        b.q    = 2'(k);
        b.d    = 16'((d >> (4 * k)) & 16'hF);
        pend.push_back(b);
      end
    end else begin
      b.en   = !bad;
      b.err  = bad;
      b.busy = 1'b0;
      b.rg   = rg;
      b.q    = q;
      b.d    = d & 16'hF;
      pend.push_back(b);
    end
  endtask

  // Advance one clock and update the model; leaves time at posedge + 1.
  task automatic step();
    logic ea, eb;
    ea = exp_a_rdy();
    eb = exp_b_rdy();
    @(posedge clk);
    fired_a = 1'b0;
    fired_b = 1'b0;
    if (reset) begin
      pend.delete();
      cur    = '0;
      last_b = 1'b1;
    end else begin
      fired_a = a_valid && ea;
      fired_b = b_valid && eb;
      if (fired_a) accept(a_reg, a_data, a_word, a_quarter);
      else if (fired_b) accept(b_reg, b_data, b_word, b_quarter);
      if (fired_a || fired_b) last_b = fired_b;
      if (pend.size() > 0) begin
        cur = pend.pop_front();
      end else begin
        cur.en   = 1'b0;
        cur.err  = 1'b0;
        cur.busy = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_valid = 1'b0; a_reg = '0; a_data = '0; a_word = 1'b0; a_quarter = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0; b_word = 1'b0; b_quarter = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (seen() !== beat_t'(0)) $display("FAIL reset_outputs: got %h want 0", seen());
      else n_pass++;
      n_checks++;
      if ({a_ready, b_ready} !== 2'b00)
        $display("FAIL reset_ready: got %b want 00", {a_ready, b_ready});
      else n_pass++;
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_nibble();
    a_valid = 1'b1; a_reg = 4'd2; a_data = 16'h0005; a_word = 1'b0; a_quarter = 2'd1;
    #1;
    n_checks++;
    if ({a_ready, b_ready} !== {exp_a_rdy(), exp_b_rdy()})
      $display("FAIL nibble_ready: got %b want %b", {a_ready, b_ready},
               {exp_a_rdy(), exp_b_rdy()});
    else n_pass++;
    step();
    a_valid = 1'b0;
    n_checks++;
    if (seen() !== {1'b1, 1'b0, 1'b0, 4'd2, 2'd1, 16'h0005})
      $display("FAIL nibble_write: got %h want %h", seen(),
               {1'b1, 1'b0, 1'b0, 4'd2, 2'd1, 16'h0005});
    else n_pass++;
    step();
    n_checks++;
    if (seen() !== cur) $display("FAIL nibble_after: got %h want %h", seen(), cur);
    else n_pass++;
    // Upper data bits must not leak into wr_data.
    a_valid = 1'b1; a_reg = 4'd6; a_data = 16'hABC7; a_quarter = 2'd3;
    #1;
    step();
    a_valid = 1'b0;
    n_checks++;
    if (seen() !== {1'b1, 1'b0, 1'b0, 4'd6, 2'd3, 16'h0007})
      $display("FAIL nibble_zero_fill: got %h want %h", seen(),
               {1'b1, 1'b0, 1'b0, 4'd6, 2'd3, 16'h0007});
    else n_pass++;
    step();
  endtask

  task automatic test_word();
    logic [15:0] nibs [4];
    nibs[0] = 16'h000F; nibs[1] = 16'h000E; nibs[2] = 16'h000E; nibs[3] = 16'h000B;
    b_valid = 1'b1; b_reg = 4'd4; b_data = 16'hBEEF; b_word = 1'b1; b_quarter = 2'd0;
    #1;
    step();
    b_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({wr_en, wr_reg, wr_quarter, wr_data, busy} !==
          {1'b1, 4'd4, 2'(k), nibs[k], (k < 3)})
        $display("FAIL word_beat%0d: got %h want %h", k,
                 {wr_en, wr_reg, wr_quarter, wr_data, busy},
                 {1'b1, 4'd4, 2'(k), nibs[k], (k < 3)});
      else n_pass++;
      n_checks++;
      if (b_ready !== (k == 3))
        $display("FAIL word_b_ready%0d: got %b want %b", k, b_ready, (k == 3));
      else n_pass++;
      step();
    end
    n_checks++;
    if (seen() !== cur) $display("FAIL word_after: got %h want %h", seen(), cur);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [3:0] grants;
    logic [3:0] want;
`ifdef WB_RR_EN
    want = 4'b1010;
`else
    want = 4'b0000;
`endif
    a_valid = 1'b1; a_reg = 4'd1; a_data = 16'h0003; a_word = 1'b0; a_quarter = 2'd0;
    b_valid = 1'b1; b_reg = 4'd3; b_data = 16'h000C; b_word = 1'b0; b_quarter = 2'd2;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({a_ready, b_ready} !== {exp_a_rdy(), exp_b_rdy()})
        $display("FAIL contend_ready%0d: got %b want %b", i, {a_ready, b_ready},
                 {exp_a_rdy(), exp_b_rdy()});
      else n_pass++;
      step();
      grants[i] = (wr_reg == 4'd3);
      n_checks++;
      if (seen() !== cur) $display("FAIL contend_out%0d: got %h want %h", i, seen(), cur);
      else n_pass++;
    end
    n_checks++;
    if (grants !== want) $display("FAIL contend_grants: got %b want %b", grants, want);
    else n_pass++;
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
  endtask

  task automatic test_invalid();
    a_valid = 1'b1; a_reg = 4'd9; a_data = 16'h1234; a_word = 1'b1;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) $display("FAIL invalid_ready: got %b want 1", a_ready);
    else n_pass++;
    step();
    a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({wr_en, err, busy} !== {1'b0, (k == 0), (k < 3)})
        $display("FAIL invalid_beat%0d: got %b want %b", k, {wr_en, err, busy},
                 {1'b0, (k == 0), (k < 3)});
      else n_pass++;
      n_checks++;
      if (seen() !== cur) $display("FAIL invalid_model%0d: got %h want %h", k, seen(), cur);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_reset_mid_word();
    a_valid = 1'b1; a_reg = 4'd5; a_data = 16'h9876; a_word = 1'b1;
    #1;
    step();
    a_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({a_ready, b_ready} !== 2'b00)
      $display("FAIL midreset_ready: got %b want 00", {a_ready, b_ready});
    else n_pass++;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({wr_en, busy} !== 2'b00)
        $display("FAIL midreset_quiet%0d: got %b want 00", i, {wr_en, busy});
      else n_pass++;
      step();
    end
    b_valid = 1'b1; b_reg = 4'd6; b_data = 16'h00A9; b_word = 1'b0; b_quarter = 2'd2;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) $display("FAIL midreset_ready_back: got %b want 1", b_ready);
    else n_pass++;
    step();
    b_valid = 1'b0;
    n_checks++;
    if (seen() !== {1'b1, 1'b0, 1'b0, 4'd6, 2'd2, 16'h0009})
      $display("FAIL midreset_write: got %h want %h", seen(),
               {1'b1, 1'b0, 1'b0, 4'd6, 2'd2, 16'h0009});
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h5A3C; a_word = 1'b1;
    #1;
    step();
    a_word = 1'b0; a_reg = 4'd7; a_data = 16'h0004; a_quarter = 2'd2;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (wr_en !== 1'b1) $display("FAIL b2b_wr_en%0d: got %b want 1", i, wr_en);
      else n_pass++;
      n_checks++;
      if (seen() !== cur) $display("FAIL b2b_out%0d: got %h want %h", i, seen(), cur);
      else n_pass++;
      n_checks++;
      if (a_ready !== exp_a_rdy())
        $display("FAIL b2b_ready%0d: got %b want %b", i, a_ready, exp_a_rdy());
      else n_pass++;
      step();
      if (fired_a) a_valid = 1'b0;
      #1;
    end
    n_checks++;
    if (wr_en !== 1'b0) $display("FAIL b2b_end: got %b want 0", wr_en);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!a_valid || fired_a) begin
        a_valid   = 1'($urandom_range(0, 1));
        a_reg     = 4'($urandom_range(0, 9));
        a_data    = 16'($urandom);
        a_word    = ($urandom_range(0, 3) == 0);
        a_quarter = 2'($urandom);
      end
      if (!b_valid || fired_b) begin
        b_valid   = 1'($urandom_range(0, 1));
        b_reg     = 4'($urandom_range(0, 9));
        b_data    = 16'($urandom);
        b_word    = ($urandom_range(0, 3) == 0);
        b_quarter = 2'($urandom);
      end
      reset = ($urandom_range(0, 63) == 0);
      #1;
      n_checks++;
      if ({a_ready, b_ready} !== {exp_a_rdy(), exp_b_rdy()})
        $display("FAIL rand_ready%0d: got %b want %b", c, {a_ready, b_ready},
                 {exp_a_rdy(), exp_b_rdy()});
      else n_pass++;
      step();
      n_checks++;
      if (seen() !== cur) $display("FAIL rand_out%0d: got %h want %h", c, seen(), cur);
      else n_pass++;
    end
    reset = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    fired_a = 1'b0;
    fired_b = 1'b0;
    last_b  = 1'b1;
    cur     = '0;
    test_reset();
    test_nibble();
    test_word();
    test_contention();
    test_invalid();
    test_reset_mid_word();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
